sim_memory_bus: RTL and testbench
=================================

SIM_MEMORY_BUS -- requirements
Module: sim_memory_bus

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 13, word-address bits of RAM (2^ADDR_WIDTH x 32-bit words).
REQ-002 SHALL have parameter READ_LATENCY, default 1, cycles from request to mem_rdata, legal 1..4.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, console FIFO entries, power of two, 2..256.
REQ-004 SHALL have parameters MEM_BASE 'h00000000, CONS_ADDR 'h10000000, EXIT_ADDR 'h10001000, CYCLE_ADDR 'h10002000 (byte addresses, word aligned).
REQ-005 SHALL have parameter INIT_FILE, default "", hex image loaded into RAM at time zero when non-empty.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 mem_wren  input  1  write strobe for current address.
REQ-009 mem_wmask  input  4  byte enables, bit n = byte n.
REQ-010 mem_wdata  input  32  write data.
REQ-011 mem_addr  input  32  byte address; bits[1:0] ignored.
REQ-012 mem_rdata  output  32  read data, READ_LATENCY cycles after address.
REQ-013 cons_valid / cons_data / cons_ready  output 1 / output 8 / input 1  console byte stream, valid-ready.
REQ-014 exit_valid / exit_code  output 1 / output 31  simulation-end request and code.
REQ-015 bad_access  output  1  sticky: access outside all decoded regions.

Function
REQ-016 Every cycle SHALL be a read of mem_addr; a cycle with mem_wren=1 SHALL also write (read returns pre-write data).
REQ-017 RAM region: MEM_BASE <= addr < MEM_BASE + 4*2^ADDR_WIDTH; writes SHALL update only bytes with mask bit set.
REQ-018 Read data SHALL pass through exactly READ_LATENCY register stages; latency SHALL be identical for RAM and MMIO reads.
REQ-019 Write to CONS_ADDR with wmask[0]=1 SHALL push wdata[7:0] into the console FIFO; other mask bits ignored.
REQ-020 Push while FIFO full SHALL drop the byte and set sticky overflow flag; FIFO contents unchanged.
REQ-021 Pop SHALL occur when cons_valid & cons_ready; cons_valid = FIFO non-empty; cons_data = head entry, stable while valid & !ready.
REQ-022 Simultaneous push and pop SHALL keep count unchanged; when full, a simultaneous pop SHALL make room so the push is accepted (no overflow).
REQ-023 Read of CONS_ADDR+4 SHALL return {16'b0, count[7:0], 6'b0, overflow, full}; read of CONS_ADDR SHALL return 0.
REQ-024 Write to EXIT_ADDR with wmask[0]=1 and wdata[0]=1 SHALL set exit_valid next cycle and latch exit_code = wdata[31:1]; sticky until reset; later writes ignored.
REQ-025 Any access (read or write) outside RAM and all MMIO addresses SHALL set bad_access next cycle; writes ignored, reads return 0.
REQ-026 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.

Reset
REQ-027 While rst=1: FIFO emptied, overflow=0, exit_valid=0, exit_code=0, bad_access=0, read pipeline zeroed, cycle counter=0, cons_valid=0, mem_rdata=0 from the following edge.
REQ-028 RAM contents SHALL NOT be affected by reset; writes during rst SHALL be ignored.
REQ-029 Reset asserted mid-transfer SHALL discard in-flight reads and any unpopped bytes.

Configuration
REQ-030 With `SIM_MEMORY_CYCLE_COUNTER_EN defined: 32-bit free-running counter, +1 per cycle out of reset, wraps at 2^32, readable at CYCLE_ADDR (value at request cycle); writes to CYCLE_ADDR ignored.
REQ-031 Without the macro: no counter logic; CYCLE_ADDR treated as undecoded (read 0, sets bad_access).

Verification
REQ-032 Write 'hAABBCCDD mask 4'b0101 to 'h40 over 'h11223344, READ_LATENCY=3 -> read of 'h40 returns 'h11BB33DD exactly 3 cycles later.
REQ-033 cons_ready=0, push 17 bytes 'h41.. with FIFO_DEPTH=16 -> status reads full=1, overflow=1, count=16; then ready=1 pops 'h41..'h50 in order.
REQ-034 FIFO full, cons_ready=1 and push 'h5A same cycle -> no overflow, count stays 16, 'h5A emerges last.
REQ-035 Write 'h00000007 to EXIT_ADDR -> exit_valid=1 next cycle, exit_code=3; subsequent write 'h9 leaves exit_code=3.
REQ-036 Read of 'h20000000 -> mem_rdata=0, bad_access=1; assert rst one cycle -> bad_access=0, cons_valid=0, RAM word 'h40 still 'h11BB33DD.
REQ-037 With macro, read CYCLE_ADDR 10 cycles after reset release -> value 10; without macro -> 0 and bad_access=1.

Source files
------------

// File: rtl/sim_memory_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : sim_memory_bus_if
// Description : Bus bundle for sim_memory_bus. It carries the unified
//               read/write memory port, the console byte stream, the
//               simulation-exit request and the bad-access flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface sim_memory_bus_if;
    logic        mem_wren;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        cons_valid;
    logic [7:0]  cons_data;
    logic        cons_ready;
    logic        exit_valid;
    logic [30:0] exit_code;
    logic        bad_access;

    // Requester side: drives the memory port and accepts console bytes
    modport master (
        output mem_wren, mem_wmask, mem_wdata, mem_addr, cons_ready,
        input  mem_rdata, cons_valid, cons_data, exit_valid, exit_code, bad_access
    );

    // Memory side: the sim_memory_bus itself
    modport slave (
        input  mem_wren, mem_wmask, mem_wdata, mem_addr, cons_ready,
        output mem_rdata, cons_valid, cons_data, exit_valid, exit_code, bad_access
    );
endinterface
`default_nettype wire

// File: rtl/sim_memory_bus.sv
`default_nettype none
// ============================================================================
// Module      : sim_memory_bus
// Description : Simulation memory. It holds word-addressed RAM with byte
//               masks, a console FIFO, an exit register and a sticky
//               bad-access flag. Every cycle performs a read. Read data
//               passes through READ_LATENCY register stages. Define
//               SIM_MEMORY_CYCLE_COUNTER_EN to map a free-running cycle
//               counter at CYCLE_ADDR.
// Revision    : 1.0 - initial release
// ============================================================================
module sim_memory_bus #(
    parameter int          ADDR_WIDTH   = 13,
    parameter int          READ_LATENCY = 1,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] MEM_BASE     = 32'h0000_0000,
    parameter logic [31:0] CONS_ADDR    = 32'h1000_0000,
    parameter logic [31:0] EXIT_ADDR    = 32'h1000_1000,
    parameter logic [31:0] CYCLE_ADDR   = 32'h1000_2000,
    parameter string       INIT_FILE    = ""
) (
    input  logic             clk,
    input  logic             rst,
    sim_memory_bus_if.slave  bus
);

    localparam int                 c_words = 1 << ADDR_WIDTH;
    localparam int                 c_ptr_w = $clog2(FIFO_DEPTH);
    localparam logic [c_ptr_w:0]   c_depth = (c_ptr_w + 1)'(FIFO_DEPTH);
    localparam logic [31:0]        c_stat_addr = CONS_ADDR + 32'd4;

    // ------------------------------------------------------------------
    // Address decode (byte address, low two bits ignored)
    // ------------------------------------------------------------------
    logic [31:0]           w_off;
    logic                  w_ram_hit;
    logic [ADDR_WIDTH-1:0] w_ram_idx;
    logic                  w_cons_hit;
    logic                  w_stat_hit;
    logic                  w_exit_hit;
    logic                  w_cyc_hit;
    logic                  w_any_hit;
    logic                  w_unused;

    assign w_off      = bus.mem_addr - MEM_BASE;
    assign w_ram_hit  = (bus.mem_addr >= MEM_BASE) && ((w_off >> (ADDR_WIDTH + 2)) == 32'd0);
    assign w_ram_idx  = w_off[ADDR_WIDTH+1:2];
    assign w_cons_hit = (bus.mem_addr[31:2] == CONS_ADDR[31:2]);
    assign w_stat_hit = (bus.mem_addr[31:2] == c_stat_addr[31:2]);
    assign w_exit_hit = (bus.mem_addr[31:2] == EXIT_ADDR[31:2]);
`ifdef SIM_MEMORY_CYCLE_COUNTER_EN
    assign w_cyc_hit  = (bus.mem_addr[31:2] == CYCLE_ADDR[31:2]);
    assign w_unused   = &{1'b0, w_off[1:0]};
`else
    // Without the counter the cycle address is an ordinary hole in the map
    assign w_cyc_hit  = 1'b0;
    assign w_unused   = &{1'b0, w_off[1:0], CYCLE_ADDR};
`endif
    assign w_any_hit  = w_ram_hit | w_cons_hit | w_stat_hit | w_exit_hit | w_cyc_hit;

    // ------------------------------------------------------------------
    // RAM (contents survive reset)
    // ------------------------------------------------------------------
    logic [31:0] r_ram [0:c_words-1];

    // Byte-masked RAM write; reset only blocks the write, never clears contents
    always @(posedge clk) begin
        if (!rst && bus.mem_wren && w_ram_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_wmask[b]) begin
                    r_ram[w_ram_idx][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Console FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_fifo [0:FIFO_DEPTH-1];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_ptr_w:0]   r_count;
    logic               r_overflow;
    logic               w_full;
    logic               w_push_req;
    logic               w_pop;
    logic               w_push;
    logic [7:0]         w_count8;

    assign w_full     = (r_count == c_depth);
    assign w_push_req = !rst && bus.mem_wren && w_cons_hit && bus.mem_wmask[0];
    assign w_pop      = (r_count != '0) && bus.cons_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_count8   = 8'(r_count);

    assign bus.cons_valid = (r_count != '0);
    assign bus.cons_data  = r_fifo[r_rptr];

    // FIFO storage write; no reset needed because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= bus.mem_wdata[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_w'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (c_ptr_w + 1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (c_ptr_w + 1)'(1);
            end
            if (w_push_req && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional cycle counter
    // ------------------------------------------------------------------
`ifdef SIM_MEMORY_CYCLE_COUNTER_EN
    logic [31:0] r_cycle;

    // Free-running counter, zero in the first cycle after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Exit request and bad-access flag
    // ------------------------------------------------------------------
    logic        r_exit_valid;
    logic [30:0] r_exit_code;
    logic        r_bad_access;

    // First qualifying exit write wins; the bad-access flag is sticky
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exit_valid <= 1'b0;
            r_exit_code  <= '0;
            r_bad_access <= 1'b0;
        end else begin
            if (!r_exit_valid && bus.mem_wren && w_exit_hit &&
                bus.mem_wmask[0] && bus.mem_wdata[0]) begin
                r_exit_valid <= 1'b1;
                r_exit_code  <= bus.mem_wdata[31:1];
            end
            if (!w_any_hit) begin
                r_bad_access <= 1'b1;
            end
        end
    end

    assign bus.exit_valid = r_exit_valid;
    assign bus.exit_code  = r_exit_code;
    assign bus.bad_access = r_bad_access;

    // ------------------------------------------------------------------
    // Read mux and latency pipeline
    // ------------------------------------------------------------------
    logic [31:0] w_rdata;
    logic [31:0] r_pipe [0:READ_LATENCY-1];

    // Select read source from pre-write state; undecoded and write-only regions read 0
    always_comb begin
        w_rdata = '0;
        if (w_ram_hit) begin
            w_rdata = r_ram[w_ram_idx];
        end else if (w_stat_hit) begin
            w_rdata = {16'b0, w_count8, 6'b0, r_overflow, w_full};
        end
`ifdef SIM_MEMORY_CYCLE_COUNTER_EN
        else if (w_cyc_hit) begin
            w_rdata = r_cycle;
        end
`endif
    end

    // Same number of stages for every source so latency never depends on address
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_rdata;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign bus.mem_rdata = r_pipe[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_sim_memory_bus.sv
`default_nettype none
// ============================================================================
// Module      : tb_sim_memory_bus
// Description : Scoreboard bench for sim_memory_bus with READ_LATENCY=3 and
//               FIFO_DEPTH=16. Stimulus queues the expected responses, and a
//               negedge monitor compares them with the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sim_memory_bus;

    localparam int          c_rl    = 3;
    localparam logic [31:0] c_cons  = 32'h1000_0000;
    localparam logic [31:0] c_stat  = 32'h1000_0004;
    localparam logic [31:0] c_exit  = 32'h1000_1000;
    localparam logic [31:0] c_cycle = 32'h1000_2000;

    localparam int k_rdata = 0;
    localparam int k_exitv = 1;
    localparam int k_exitc = 2;
    localparam int k_bad   = 3;
    localparam int k_consv = 4;

    logic clk;
    logic rst;
    int   cyc      = 0;
    int   vectors  = 0;
    int   miscomp  = 0;

    sim_memory_bus_if bus();

    sim_memory_bus #(
        .ADDR_WIDTH   (13),
        .READ_LATENCY (c_rl),
        .FIFO_DEPTH   (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard queues: timed flag/data checks and the console byte order
    int          due_q[$];
    int          kind_q[$];
    logic [31:0] val_q[$];
    string       name_q[$];
    logic [7:0]  cons_q[$];

    task automatic expect_at(input int due, input int kind, input logic [31:0] v, input string n);
        due_q.push_back(due);
        kind_q.push_back(kind);
        val_q.push_back(v);
        name_q.push_back(n);
    endtask

    // One bus cycle: drive request, advance to just after the next edge
    task automatic op(input logic we, input logic [3:0] m, input logic [31:0] d, input logic [31:0] a);
        bus.mem_wren  = we;
        bus.mem_wmask = m;
        bus.mem_wdata = d;
        bus.mem_addr  = a;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic do_reset(input int n);
        cons_q.delete();
        rst = 1'b1;
        for (int i = 0; i < n; i++) op(1'b1, 4'hF, 32'h0, 32'h40);
        rst = 1'b0;
    endtask

    task automatic drain();
        bus.cons_ready = 1'b1;
        for (int k = 0; k < 40 && cons_q.size() != 0; k++) idle(1);
        bus.cons_ready = 1'b0;
        vectors++;
        if (cons_q.size() != 0) begin
            miscomp++;
            $display("FAIL drain: %0d bytes still expected, required 0", cons_q.size());
            cons_q.delete();
        end
    endtask

    // Monitor: compare everything due this cycle and every console handshake
    always @(negedge clk) begin
        logic [31:0] act;
        for (int i = due_q.size() - 1; i >= 0; i--) begin
            if (due_q[i] == cyc) begin
                case (kind_q[i])
                    k_rdata: act = bus.mem_rdata;
                    k_exitv: act = {31'b0, bus.exit_valid};
                    k_exitc: act = {1'b0, bus.exit_code};
                    k_bad:   act = {31'b0, bus.bad_access};
                    default: act = {31'b0, bus.cons_valid};
                endcase
                vectors++;
                if (act !== val_q[i]) begin
                    miscomp++;
                    $display("FAIL %s: got %h required %h (cycle %0d)", name_q[i], act, val_q[i], cyc);
                end
                due_q.delete(i);
                kind_q.delete(i);
                val_q.delete(i);
                name_q.delete(i);
            end
        end
        if (!rst && bus.cons_valid && bus.cons_ready) begin
            vectors++;
            if (cons_q.size() == 0) begin
                miscomp++;
                $display("FAIL cons_extra: got byte %h required none (cycle %0d)", bus.cons_data, cyc);
            end else begin
                if (bus.cons_data !== cons_q[0]) begin
                    miscomp++;
                    $display("FAIL cons_data: got %h required %h (cycle %0d)", bus.cons_data, cons_q[0], cyc);
                end
                void'(cons_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.cons_ready = 1'b0;
        bus.mem_wren   = 1'b0;
        bus.mem_wmask  = 4'h0;
        bus.mem_wdata  = 32'h0;
        bus.mem_addr   = 32'h0;
        @(posedge clk); #1;
        do_reset(3);

        // Reset state
        expect_at(cyc, k_rdata, 32'h0, "rst_rdata");
        expect_at(cyc, k_exitv, 32'h0, "rst_exit_valid");
        expect_at(cyc, k_bad,   32'h0, "rst_bad");
        expect_at(cyc, k_consv, 32'h0, "rst_cons_valid");

        // RAM byte masks, read-before-write and exact latency
        op(1'b1, 4'hF, 32'h1122_3344, 32'h40);
        expect_at(cyc + c_rl, k_rdata, 32'h1122_3344, "rd_prewrite");
        op(1'b1, 4'h5, 32'hAABB_CCDD, 32'h40);
        op(1'b1, 4'hF, 32'hDEAD_BEEF, 32'h44);
        expect_at(cyc + c_rl, k_rdata, 32'h11BB_33DD, "rd_mask0101");
        op(1'b0, 4'h0, 32'h0, 32'h40);
        expect_at(cyc + c_rl, k_rdata, 32'hDEAD_BEEF, "rd_prewrite2");
        op(1'b1, 4'hA, 32'h1234_5678, 32'h44);
        expect_at(cyc + c_rl, k_rdata, 32'h12AD_56EF, "rd_mask1010");
        op(1'b0, 4'h0, 32'h0, 32'h44);
        expect_at(cyc + c_rl, k_rdata, 32'h11BB_33DD, "rd_lowbits");
        op(1'b0, 4'h0, 32'h0, 32'h43);
        op(1'b1, 4'hF, 32'hCAFE_F00D, 32'h7FFC);
        expect_at(cyc + c_rl, k_rdata, 32'hCAFE_F00D, "rd_ram_top");
        op(1'b0, 4'h0, 32'h0, 32'h7FFC);
        expect_at(cyc + c_rl, k_rdata, 32'h0, "stat_empty");
        op(1'b0, 4'h0, 32'h0, c_stat);
        idle(4);

        // Console: mask bit 0 clear does not push; 17 pushes overflow by one
        op(1'b1, 4'hE, 32'h99, c_cons);
        for (int i = 0; i < 17; i++) begin
            logic [7:0] b;
            b = 8'(8'h41 + i);
            if (i < 16) cons_q.push_back(b);
            op(1'b1, (i % 2 == 0) ? 4'h1 : 4'hF, {24'hFFFFFF, b}, c_cons);
        end
        expect_at(cyc + c_rl, k_rdata, 32'h0000_1003, "stat_full_ovf");
        op(1'b0, 4'h0, 32'h0, c_stat);
        expect_at(cyc + c_rl, k_rdata, 32'h0, "cons_data_read");
        op(1'b0, 4'h0, 32'h0, c_cons);
        idle(3);
        drain();
        expect_at(cyc + c_rl, k_rdata, 32'h0000_0002, "stat_drained");
        op(1'b0, 4'h0, 32'h0, c_stat);
        idle(3);

        // Reset mid-transfer discards queued bytes and the in-flight read
        for (int i = 0; i < 3; i++) op(1'b1, 4'h1, 32'h71 + i, c_cons);
        op(1'b0, 4'h0, 32'h0, 32'h40);
        do_reset(1);
        expect_at(cyc, k_consv, 32'h0, "rst_mid_cons_valid");
        expect_at(cyc, k_rdata, 32'h0, "rst_mid_rdata");

        // Full FIFO with simultaneous pop and push: accepted, no overflow
        for (int i = 0; i < 16; i++) begin
            cons_q.push_back(8'(8'h60 + i));
            op(1'b1, 4'h1, 32'h60 + i, c_cons);
        end
        bus.cons_ready = 1'b1;
        cons_q.push_back(8'h5A);
        op(1'b1, 4'h1, 32'h5A, c_cons);
        bus.cons_ready = 1'b0;
        expect_at(cyc + c_rl, k_rdata, 32'h0000_1001, "stat_full_no_ovf");
        op(1'b0, 4'h0, 32'h0, c_stat);
        idle(3);
        drain();

        // Exit register
        op(1'b1, 4'hF, 32'h6, c_exit);
        expect_at(cyc, k_exitv, 32'h0, "exit_bit0_clear");
        expect_at(cyc + 1, k_exitv, 32'h1, "exit_valid");
        expect_at(cyc + 1, k_exitc, 32'h3, "exit_code");
        op(1'b1, 4'hF, 32'h7, c_exit);
        expect_at(cyc + 1, k_exitc, 32'h3, "exit_code_sticky");
        op(1'b1, 4'hF, 32'h9, c_exit);
        expect_at(cyc + 1, k_bad, 32'h0, "exit_read_not_bad");
        expect_at(cyc + c_rl, k_rdata, 32'h0, "exit_read_zero");
        op(1'b0, 4'h0, 32'h0, c_exit);
        idle(3);

        // Cycle counter region, 10 cycles after reset release
        do_reset(3);
        expect_at(cyc, k_bad,   32'h0, "rst2_bad");
        expect_at(cyc, k_exitv, 32'h0, "rst2_exit_valid");
        expect_at(cyc, k_exitc, 32'h0, "rst2_exit_code");
        idle(10);
`ifdef SIM_MEMORY_CYCLE_COUNTER_EN
        expect_at(cyc + c_rl, k_rdata, 32'd10, "cycle_read");
        expect_at(cyc + 1,    k_bad,   32'h0,  "cycle_not_bad");
`else
        expect_at(cyc + c_rl, k_rdata, 32'h0, "cycle_read_zero");
        expect_at(cyc + 1,    k_bad,   32'h1, "cycle_bad");
`endif
        op(1'b0, 4'h0, 32'h0, c_cycle);
        idle(3);

        // Undecoded read, then one-cycle reset with a write that must be ignored
        expect_at(cyc + c_rl, k_rdata, 32'h0, "bad_rdata");
        expect_at(cyc + 1,    k_bad,   32'h1, "bad_set");
        op(1'b0, 4'h0, 32'h0, 32'h2000_0000);
        idle(3);
        do_reset(1);
        expect_at(cyc, k_bad,   32'h0, "rst3_bad");
        expect_at(cyc, k_consv, 32'h0, "rst3_cons_valid");
        expect_at(cyc, k_rdata, 32'h0, "rst3_rdata");
        expect_at(cyc + c_rl, k_rdata, 32'h11BB_33DD, "ram_survives_rst");
        op(1'b0, 4'h0, 32'h0, 32'h40);

        // Just past the end of RAM is undecoded
        expect_at(cyc, k_bad, 32'h0, "ram_end_before");
        expect_at(cyc + 1, k_bad, 32'h1, "ram_end_bad");
        expect_at(cyc + c_rl, k_rdata, 32'h0, "ram_end_rdata");
        op(1'b0, 4'h0, 32'h0, 32'h8000);
        idle(6);

        vectors++;
        if (due_q.size() != 0 || cons_q.size() != 0) begin
            miscomp++;
            $display("FAIL leftover: got %0d checks and %0d bytes pending, required 0",
                     due_q.size(), cons_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
        $finish;
    end

endmodule
`default_nettype wire
